// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
// Raster timing generator for the VGA display path. A horizontal and a
// vertical counter advance on the pixel tick pix_en; sync pulses, the
// active-area strobe and a frame-start pulse are decoded from the counter
// values about to be loaded. Those outputs therefore line up with x/y in the
// same cycle.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous reset, active-low
//   pix_en      pixel tick; counters advance only on clk edges with pix_en=1
//   hsync       horizontal sync, registered, active level SYNC_POL
//   vsync       vertical sync, registered, active level SYNC_POL
//   read_pixel  1 inside the visible area; selects pixel data vs. black
//   x           horizontal counter (pixel within line)
//   y           vertical counter (line within frame)
//   frame_start one-clk pulse when the counters become (0,0)
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             read_pixel,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries, all unsigned at CNT_W bits.
  localparam logic [CNT_W-1:0] H_FRONT_START = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_BACK_START  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST        = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_FRONT_START = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_START  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_BACK_START  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST        = CNT_W'(V_TOTAL - 1);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  // Each axis walks ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE as its counter
  // advances; the region is a pure function of the counter value.
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } region_t;

  function automatic region_t h_region(input logic [CNT_W-1:0] c);
    region_t r;
    if (c < H_FRONT_START)     r = ACTIVE;
    else if (c < H_SYNC_START) r = FRONT;
    else if (c < H_BACK_START) r = SYNC;
    else                       r = BACK;
    return r;
  endfunction

  function automatic region_t v_region(input logic [CNT_W-1:0] c);
    region_t r;
    if (c < V_FRONT_START)     r = ACTIVE;
    else if (c < V_SYNC_START) r = FRONT;
    else if (c < V_BACK_START) r = SYNC;
    else                       r = BACK;
    return r;
  endfunction

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_wrap;
  region_t          h_reg_nxt;
  region_t          v_reg_nxt;

  // Next counter values; the vertical counter only moves on a line wrap.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
    h_reg_nxt = h_region(h_nxt);
    v_reg_nxt = v_region(v_nxt);
  end

  // Counter/output register stage: outputs are decoded from the values being
  // loaded so they stay aligned with x/y. Reset parks the raster on the last
  // back-porch pixel so the first tick lands on (0,0) with frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      read_pixel  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      hsync       <= (h_reg_nxt == SYNC) ? SYNC_ON : SYNC_OFF;
      vsync       <= (v_reg_nxt == SYNC) ? SYNC_ON : SYNC_OFF;
      read_pixel  <= (h_reg_nxt == ACTIVE) && (v_reg_nxt == ACTIVE);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end else begin
      // Level outputs hold between ticks; the frame pulse is one clk wide.
      frame_start <= 1'b0;
    end
  end

  assign x = h_cnt;
  assign y = v_cnt;

endmodule
